logic_reset_sequencer: RTL and testbench

LOGIC_RESET_SEQUENCER -- requirements
Module: logic_reset_sequencer

---
 rtl/logic_reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_logic_reset_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/logic_reset_sequencer.sv
// Reset sequencer: waits for a stable, synchronized PLL lock and then releases
// reset_n bit by bit (bit 0 first), STAGE_DELAY clocks apart. Loss of lock or a
// restart request drops every reset at once and re-runs the full sequence.
module logic_reset_sequencer #(
  parameter int unsigned CLOCK_FREQUENCY_HZ   = 100_000_000,
  parameter int unsigned RESET_OUTPUTS        = 4,
  parameter int unsigned STAGE_DELAY_NS       = 100,
  parameter int unsigned LOCKED_SYNC_STAGES   = 2,
  parameter int unsigned LOCKED_STABLE_CLOCKS = 16
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     locked,
  input  logic                     restart,
  output logic [RESET_OUTPUTS-1:0] reset_n,
  output logic                     ready
);

  // Rounded nanosecond-to-clock conversion in 64 bits; clamped to at least one clock.
  localparam longint unsigned SD_RAW =
    (64'(STAGE_DELAY_NS) * 64'(CLOCK_FREQUENCY_HZ) + 64'd500_000_000) / 64'd1_000_000_000;
  localparam int unsigned STAGE_DELAY = (SD_RAW < 64'd1) ? 1 : 32'(SD_RAW);
  localparam int unsigned MAX_CNT     = (STAGE_DELAY > LOCKED_STABLE_CLOCKS) ?
                                        STAGE_DELAY : LOCKED_STABLE_CLOCKS;
  localparam int unsigned CNT_W       = (MAX_CNT <= 1) ? 1 : $clog2(MAX_CNT);
  localparam int unsigned K_W         = (RESET_OUTPUTS <= 1) ? 1 : $clog2(RESET_OUTPUTS);

  if (CLOCK_FREQUENCY_HZ < 1 || CLOCK_FREQUENCY_HZ > 1_000_000_000) begin : g_drc_freq
    $error("CLOCK_FREQUENCY_HZ out of range 1..1_000_000_000");
  end
  if (RESET_OUTPUTS < 1 || RESET_OUTPUTS > 16) begin : g_drc_outputs
    $error("RESET_OUTPUTS out of range 1..16");
  end
  if (LOCKED_SYNC_STAGES < 2) begin : g_drc_sync
    $error("LOCKED_SYNC_STAGES must be at least 2");
  end
  if (LOCKED_STABLE_CLOCKS < 1) begin : g_drc_stable
    $error("LOCKED_STABLE_CLOCKS must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [RESET_OUTPUTS-1:0] rst_q, rst_d;
  logic                     ready_q, ready_d;
  logic [LOCKED_SYNC_STAGES-1:0] sync_q;
  logic                     locked_sync;
  logic                     abort;

  // Synchronizer chain for the asynchronous locked input.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCKED_SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_sync = sync_q[LOCKED_SYNC_STAGES-1];
  assign abort       = !locked_sync || restart;

  // State register together with counter, stage index and output flops.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      k_q     <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; the abort override sits last so it wins over any release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_sync) begin
          if (cnt_q == CNT_W'(LOCKED_STABLE_CLOCKS - 1)) begin
            state_d = RELEASE;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
          // Shifting a one in from the bottom keeps reset_n thermometer-coded.
          rst_d = RESET_OUTPUTS'({rst_q, 1'b1});
          cnt_d = '0;
          if (k_q == K_W'(RESET_OUTPUTS - 1)) begin
            state_d = DONE;
            ready_d = 1'b1;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        rst_d   = '1;
        ready_d = 1'b1;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      k_d     = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    reset_n = rst_q;
    ready   = ready_q;
  end

endmodule

// File: tb/tb_logic_reset_sequencer.sv
// Directed bench for logic_reset_sequencer: expected outputs are queued with the
// edge number they apply to and compared 1 time unit after that edge.
module tb_logic_reset_sequencer;

  logic       aclk = 1'b0;
  logic       areset_n;
  logic       locked;
  logic       restart;
  logic [2:0] rn0;
  logic       rdy0;
  logic [2:0] rn1;
  logic       rdy1;
  logic [0:0] rn2;
  logic       rdy2;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          edge_cnt = 0;
  int          base;

  typedef struct {
    int         e;
    int         dut;
    logic [2:0] rn;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t q[$];

  always #5 aclk = ~aclk;

  // Main DUT: STAGE_DELAY = 10, N = 3
  logic_reset_sequencer #(
    .CLOCK_FREQUENCY_HZ(100_000_000), .RESET_OUTPUTS(3), .STAGE_DELAY_NS(100),
    .LOCKED_SYNC_STAGES(2), .LOCKED_STABLE_CLOCKS(4)
  ) dut0 (
    .aclk(aclk), .areset_n(areset_n), .locked(locked), .restart(restart),
    .reset_n(rn0), .ready(rdy0)
  );

  // Degenerate delay: 1 ns rounds to 0 clocks, clamps to 1
  logic_reset_sequencer #(
    .CLOCK_FREQUENCY_HZ(100_000_000), .RESET_OUTPUTS(3), .STAGE_DELAY_NS(1),
    .LOCKED_SYNC_STAGES(2), .LOCKED_STABLE_CLOCKS(4)
  ) dut1 (
    .aclk(aclk), .areset_n(areset_n), .locked(locked), .restart(restart),
    .reset_n(rn1), .ready(rdy1)
  );

  // Single output
  logic_reset_sequencer #(
    .CLOCK_FREQUENCY_HZ(100_000_000), .RESET_OUTPUTS(1), .STAGE_DELAY_NS(100),
    .LOCKED_SYNC_STAGES(2), .LOCKED_STABLE_CLOCKS(4)
  ) dut2 (
    .aclk(aclk), .areset_n(areset_n), .locked(locked), .restart(restart),
    .reset_n(rn2), .ready(rdy2)
  );

  task automatic expect_at(input int e, input int d, input logic [2:0] rn,
                           input logic r, input string tag);
    exp_t x;
    x.e = e; x.dut = d; x.rn = rn; x.rdy = r; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s edge=%0d: observed=%b expected=%b", tag, edge_cnt, obs, exp_v);
    end
  endtask

  task automatic check_edge();
    logic [2:0] a_rn;
    logic       a_rdy;
    logic [3:0] t0;
    logic [3:0] t1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].e == edge_cnt) begin
        case (q[i].dut)
          0:       begin a_rn = rn0;            a_rdy = rdy0; end
          1:       begin a_rn = rn1;            a_rdy = rdy1; end
          default: begin a_rn = {2'b00, rn2};   a_rdy = rdy2; end
        endcase
        check(q[i].tag, {a_rn, a_rdy}, {q[i].rn, q[i].rdy});
        q.delete(i);
      end
    end
    // Thermometer coding and ready consistency on the 3-bit instances
    t0 = {1'b0, rn0} & ({1'b0, rn0} + 4'd1);
    t1 = {1'b0, rn1} & ({1'b0, rn1} + 4'd1);
    check("therm0", t0, 4'd0);
    check("therm1", t1, 4'd0);
    check("ready0_all", {3'b000, rdy0}, {3'b000, &rn0});
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
      edge_cnt++;
      check_edge();
    end
  endtask

  initial begin
    areset_n = 1'b0;
    locked   = 1'b0;
    restart  = 1'b0;
    #12;
    check("reset_state0", {rn0, rdy0}, 4'b0000);
    check("reset_state1", {rn1, rdy1}, 4'b0000);
    run(2);
    #2 areset_n = 1'b1;
    run(2);

    // Nominal sequence, locked high from e1
    base = edge_cnt;
    locked = 1'b1;
    expect_at(base + 15, 0, 3'b000, 1'b0, "nom_pre0");
    expect_at(base + 16, 0, 3'b001, 1'b0, "nom_rel0");
    expect_at(base + 25, 0, 3'b001, 1'b0, "nom_pre1");
    expect_at(base + 26, 0, 3'b011, 1'b0, "nom_rel1");
    expect_at(base + 35, 0, 3'b011, 1'b0, "nom_pre2");
    expect_at(base + 36, 0, 3'b111, 1'b1, "nom_done");
    expect_at(base + 6,  1, 3'b000, 1'b0, "sd1_pre0");
    expect_at(base + 7,  1, 3'b001, 1'b0, "sd1_rel0");
    expect_at(base + 8,  1, 3'b011, 1'b0, "sd1_rel1");
    expect_at(base + 9,  1, 3'b111, 1'b1, "sd1_done");
    expect_at(base + 15, 2, 3'b000, 1'b0, "n1_pre");
    expect_at(base + 16, 2, 3'b001, 1'b1, "n1_rel");
    run(40);

    // Lock loss in DONE: falls right after an edge, abort three edges later
    base = edge_cnt;
    locked = 1'b0;
    expect_at(base + 2, 0, 3'b111, 1'b1, "loss_hold");
    expect_at(base + 3, 0, 3'b000, 1'b0, "loss_drop");
    expect_at(base + 3, 1, 3'b000, 1'b0, "loss_drop_sd1");
    run(6);
    base = edge_cnt;
    locked = 1'b1;
    expect_at(base + 15, 0, 3'b000, 1'b0, "relock_pre0");
    expect_at(base + 16, 0, 3'b001, 1'b0, "relock_rel0");
    expect_at(base + 36, 0, 3'b111, 1'b1, "relock_done");
    run(40);

    // One-cycle glitch sampled on the edge that would leave WAIT_LOCK
    locked = 1'b0;
    run(4);
    base = edge_cnt;
    locked = 1'b1;
    expect_at(base + 16, 0, 3'b000, 1'b0, "glitch_norel");
    expect_at(base + 19, 0, 3'b000, 1'b0, "glitch_pre0");
    expect_at(base + 20, 0, 3'b001, 1'b0, "glitch_rel0");
    run(3);
    locked = 1'b0;
    run(1);
    locked = 1'b1;
    run(41);

    // Restart on the edge where reset_n[1] would release
    locked = 1'b0;
    run(4);
    base = edge_cnt;
    locked = 1'b1;
    expect_at(base + 25, 0, 3'b001, 1'b0, "rs_pre");
    expect_at(base + 26, 0, 3'b000, 1'b0, "rs_abort");
    expect_at(base + 39, 0, 3'b000, 1'b0, "rs_pre0");
    expect_at(base + 40, 0, 3'b001, 1'b0, "rs_rel0");
    run(25);
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    run(19);

    // Async reset mid-RELEASE (dut0) and in DONE (dut1), checked without a clock edge
    #2 areset_n = 1'b0;
    #1;
    check("async_clear0", {rn0, rdy0}, 4'b0000);
    check("async_clear1", {rn1, rdy1}, 4'b0000);
    check("async_clear2", {3'b000, rdy2}, 4'b0000);
    run(3);
    #3 areset_n = 1'b1;
    base = edge_cnt;
    expect_at(base + 15, 0, 3'b000, 1'b0, "ar_pre0");
    expect_at(base + 16, 0, 3'b001, 1'b0, "ar_rel0");
    expect_at(base + 36, 0, 3'b111, 1'b1, "ar_done");
    run(40);

    check("queue_drained", 4'(q.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
